spi_master_slave: RTL and testbench

Matched 8-bit SPI master and slave pair in one block, sharing a single system clock, with the SPI bus (sclk, ss_n, mosi, miso) wired internally and also brought out for observation. Each transfer is full-duplex in SPI mode 0 (CPOL=0, CPHA=0), MSB first. The master generates the bus timing. The slave oversamples the bus in the system clock domain. This block serves as the on-chip SPI link and as the loopback reference for SPI verification.

---
 rtl/spi_master_slave.sv | 217 +++++++++++++++++++++
 tb/tb_spi_master_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// Matched SPI mode-0 master and oversampling slave sharing one system clock.
// The bus is wired internally and also driven out for observation.
module spi_master_slave #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              start_transfer,
    output logic              transfer_done,
    output logic [DATA_W-1:0] rx_data,
    input  logic [DATA_W-1:0] slave_tx_data,
    output logic [DATA_W-1:0] slave_rx_data,
    output logic              data_received,
    output logic              sclk,
    output logic              ss_n,
    output logic              mosi,
    output logic              miso
);

    localparam int unsigned DivW  = $clog2(CLK_DIV + 1);
    localparam int unsigned HalfW = $clog2(2 * DATA_W);
    localparam int unsigned CntW  = $clog2(DATA_W + 1);

    localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [HalfW-1:0] HalfLast = HalfW'(2 * DATA_W - 1);
    localparam logic [HalfW-1:0] LastFall = HalfW'(2 * DATA_W - 2);
    localparam logic [CntW-1:0]  BitsFull = CntW'(DATA_W);
    localparam logic [CntW-1:0]  BitLast  = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StTransfer, StDone} mst_state_e;

    // ---------------- master ----------------
    mst_state_e        mst_state_q, mst_state_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [HalfW-1:0]  half_cnt_q, half_cnt_d;
    logic [DATA_W-1:0] mst_tx_q, mst_tx_d;
    logic [DATA_W-1:0] mst_rx_q, mst_rx_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;

    // ---------------- slave ----------------
    logic [2:0]        sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic [DATA_W-1:0] slv_tx_q, slv_tx_d;
    logic [DATA_W-1:0] slv_rx_q, slv_rx_d;
    logic [DATA_W-1:0] slave_rx_data_q, slave_rx_data_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d;
    logic              drx_q, drx_d;
    logic              sclk_rise, sclk_fall, ss_fall, ss_low, mosi_s;

    always_comb begin
        mst_state_d = mst_state_q;
        div_cnt_d   = div_cnt_q;
        half_cnt_d  = half_cnt_q;
        mst_tx_d    = mst_tx_q;
        mst_rx_d    = mst_rx_q;
        rx_data_d   = rx_data_q;
        sclk_d      = sclk_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        done_d      = 1'b0;
        unique case (mst_state_q)
            StIdle: begin
                if (start_transfer) begin
                    mst_tx_d    = tx_data;
                    mst_rx_d    = '0;
                    ss_n_d      = 1'b0;
                    mosi_d      = tx_data[DATA_W-1];
                    div_cnt_d   = '0;
                    half_cnt_d  = '0;
                    mst_state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_cnt_q == DivLast) begin
                    // First rising edge: capture the slave's MSB.
                    div_cnt_d   = '0;
                    sclk_d      = 1'b1;
                    mst_rx_d    = {mst_rx_q[DATA_W-2:0], miso_q};
                    mst_state_d = StTransfer;
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StTransfer: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d  = '0;
                    half_cnt_d = half_cnt_q + HalfW'(1);
                    if (half_cnt_q == HalfLast) begin
                        ss_n_d      = 1'b1;
                        mosi_d      = 1'b0;
                        done_d      = 1'b1;
                        rx_data_d   = mst_rx_q;
                        mst_state_d = StDone;
                    end else if (!half_cnt_q[0]) begin
                        sclk_d = 1'b0;
                        if (half_cnt_q != LastFall) begin
                            mst_tx_d = {mst_tx_q[DATA_W-2:0], 1'b0};
                            mosi_d   = mst_tx_q[DATA_W-2];
                        end
                    end else begin
                        sclk_d   = 1'b1;
                        mst_rx_d = {mst_rx_q[DATA_W-2:0], miso_q};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StDone: begin
                mst_state_d = StIdle;
            end
            default: begin
                mst_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mst_state_q <= StIdle;
            div_cnt_q   <= '0;
            half_cnt_q  <= '0;
            mst_tx_q    <= '0;
            mst_rx_q    <= '0;
            rx_data_q   <= '0;
            sclk_q      <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mst_state_q <= mst_state_d;
            div_cnt_q   <= div_cnt_d;
            half_cnt_q  <= half_cnt_d;
            mst_tx_q    <= mst_tx_d;
            mst_rx_q    <= mst_rx_d;
            rx_data_q   <= rx_data_d;
            sclk_q      <= sclk_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
        end
    end

    // Bit [1] is the synchronized level, bit [2] the previous one for edges.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_low    = ~ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[2];

    always_comb begin
        slv_tx_d        = slv_tx_q;
        slv_rx_d        = slv_rx_q;
        slave_rx_data_d = slave_rx_data_q;
        bit_cnt_d       = bit_cnt_q;
        miso_d          = miso_q;
        drx_d           = 1'b0;
        if (!ss_low) begin
            miso_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (ss_fall) begin
            slv_tx_d  = slave_tx_data;
            slv_rx_d  = '0;
            miso_d    = slave_tx_data[DATA_W-1];
            bit_cnt_d = '0;
        end else if (sclk_rise && (bit_cnt_q < BitsFull)) begin
            slv_rx_d  = {slv_rx_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == BitLast) begin
                slave_rx_data_d = {slv_rx_q[DATA_W-2:0], mosi_s};
                drx_d           = 1'b1;
            end
        end else if (sclk_fall && (bit_cnt_q < BitsFull)) begin
            slv_tx_d = {slv_tx_q[DATA_W-2:0], 1'b0};
            miso_d   = slv_tx_q[DATA_W-2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q     <= 3'b000;
            ss_sync_q       <= 3'b111;
            mosi_sync_q     <= 3'b000;
            slv_tx_q        <= '0;
            slv_rx_q        <= '0;
            slave_rx_data_q <= '0;
            bit_cnt_q       <= '0;
            miso_q          <= 1'b0;
            drx_q           <= 1'b0;
        end else begin
            sclk_sync_q     <= {sclk_sync_q[1:0], sclk_q};
            ss_sync_q       <= {ss_sync_q[1:0], ss_n_q};
            mosi_sync_q     <= {mosi_sync_q[1:0], mosi_q};
            slv_tx_q        <= slv_tx_d;
            slv_rx_q        <= slv_rx_d;
            slave_rx_data_q <= slave_rx_data_d;
            bit_cnt_q       <= bit_cnt_d;
            miso_q          <= miso_d;
            drx_q           <= drx_d;
        end
    end

    assign transfer_done = done_q;
    assign rx_data       = rx_data_q;
    assign slave_rx_data = slave_rx_data_q;
    assign data_received = drx_q;
    assign sclk          = sclk_q;
    assign ss_n          = ss_n_q;
    assign mosi          = mosi_q;
    assign miso          = miso_q;

endmodule

// File: tb/tb_spi_master_slave.sv
// Self-checking bench for spi_master_slave: directed scenarios plus randomized
// byte exchanges checked against a transaction-level model of the link.
module tb_spi_master_slave;

    localparam int CLK_DIV = 4;
    localparam int MAX_CYC = 40 * CLK_DIV;
    localparam int SS_LOW  = 17 * CLK_DIV;

    logic       clk, rst_n, start_transfer;
    logic [7:0] tx_data, slave_tx_data;
    logic       transfer_done, data_received;
    logic [7:0] rx_data, slave_rx_data;
    logic       sclk, ss_n, mosi, miso;

    int checks = 0;
    int errors = 0;

    spi_master_slave #(.CLK_DIV(CLK_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_data        (tx_data),
        .start_transfer (start_transfer),
        .transfer_done  (transfer_done),
        .rx_data        (rx_data),
        .slave_tx_data  (slave_tx_data),
        .slave_rx_data  (slave_rx_data),
        .data_received  (data_received),
        .sclk           (sclk),
        .ss_n           (ss_n),
        .mosi           (mosi),
        .miso           (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one transfer and records what the bus and status outputs showed.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] stx, input int chg_at,
                        input logic [7:0] stx2, output logic [7:0] mo, output logic [7:0] mi,
                        output int rises, output int ss_low, output int n_done,
                        output int n_drx, output int gap, output bit timeout);
        int   done_c, drx_c;
        logic prev;
        mo = '0; mi = '0; rises = 0; ss_low = 0; n_done = 0; n_drx = 0;
        gap = -1; timeout = 1'b1; done_c = -1; drx_c = -1;
        tx_data = tx; slave_tx_data = stx; start_transfer = 1'b1;
        @(posedge clk);
        #1;
        start_transfer = 1'b0;
        prev = 1'b0;
        for (int c = 0; c < MAX_CYC; c++) begin
            if (c == chg_at) slave_tx_data = stx2;
            if (sclk && !prev) begin
                rises++;
                mo = {mo[6:0], mosi};
                mi = {mi[6:0], miso};
            end
            prev = sclk;
            if (!ss_n) ss_low++;
            if (data_received) begin
                n_drx++;
                drx_c = c;
            end
            if (transfer_done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (done_c >= 0 && drx_c >= 0) gap = done_c - drx_c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_transfer = 1'b0; tx_data = '0; slave_tx_data = '0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b want 1", ss_n); end
        checks++; if (transfer_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", transfer_done); end
        checks++; if (data_received !== 1'b0) begin errors++; $display("FAIL reset_drx: got %b want 0", data_received); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h want 00", rx_data); end
        checks++; if (slave_rx_data !== 8'h00) begin errors++; $display("FAIL reset_srx: got %h want 00", slave_rx_data); end
    endtask

    task automatic test_pattern();
        logic [7:0] mo, mi;
        int rises, ssl, nd, nr, gap;
        bit to;
        xfer(8'h5A, 8'hAA, -1, 8'h00, mo, mi, rises, ssl, nd, nr, gap, to);
        checks++; if (to) begin errors++; $display("FAIL pat_timeout: got no transfer_done want one"); end
        checks++; if (rises != 8) begin errors++; $display("FAIL pat_rises: got %0d want 8", rises); end
        checks++; if (mo !== 8'h5A) begin errors++; $display("FAIL pat_mosi_bits: got %h want 5a", mo); end
        checks++; if (mi !== 8'hAA) begin errors++; $display("FAIL pat_miso_bits: got %h want aa", mi); end
        checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL pat_rx: got %h want aa", rx_data); end
        checks++; if (slave_rx_data !== 8'h5A) begin errors++; $display("FAIL pat_srx: got %h want 5a", slave_rx_data); end
        checks++; if (nd != 1) begin errors++; $display("FAIL pat_done_cnt: got %0d want 1", nd); end
        checks++; if (nr != 1) begin errors++; $display("FAIL pat_drx_cnt: got %0d want 1", nr); end
        checks++; if (gap < 1 || gap > CLK_DIV + 4) begin
            errors++; $display("FAIL pat_drx_gap: got %0d want 1..%0d", gap, CLK_DIV + 4);
        end
        checks++; if (ssl != SS_LOW) begin errors++; $display("FAIL pat_ss_low: got %0d want %0d", ssl, SS_LOW); end
    endtask

    task automatic test_second();
        logic [7:0] mo, mi;
        int rises, ssl, nd, nr, gap;
        bit to;
        idle(10);
        xfer(8'hC3, 8'hB5, -1, 8'h00, mo, mi, rises, ssl, nd, nr, gap, to);
        checks++; if (to) begin errors++; $display("FAIL second_timeout: got no transfer_done want one"); end
        checks++; if (rx_data !== 8'hB5) begin errors++; $display("FAIL second_rx: got %h want b5", rx_data); end
        checks++; if (slave_rx_data !== 8'hC3) begin errors++; $display("FAIL second_srx: got %h want c3", slave_rx_data); end
    endtask

    task automatic test_zero_reply();
        logic [7:0] mo, mi;
        int rises, ssl, nd, nr, gap;
        bit to;
        idle(3);
        xfer(8'h12, 8'h00, -1, 8'h00, mo, mi, rises, ssl, nd, nr, gap, to);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL zero_rx: got %h want 00", rx_data); end
        checks++; if (slave_rx_data !== 8'h12) begin errors++; $display("FAIL zero_srx: got %h want 12", slave_rx_data); end
        checks++; if (ssl != SS_LOW) begin errors++; $display("FAIL zero_ss_low: got %0d want %0d", ssl, SS_LOW); end
    endtask

    task automatic test_held_start();
        int   falls, n_done, c1, c2, f2;
        logic prev_ss;
        bit   fin;
        idle(3);
        tx_data = 8'h3C; slave_tx_data = 8'h96; start_transfer = 1'b1;
        @(posedge clk);
        #1;
        falls = 1; n_done = 0; c1 = -1; c2 = -1; f2 = -1; prev_ss = ss_n; fin = 1'b0;
        for (int c = 0; c < 3 * MAX_CYC; c++) begin
            if (prev_ss && !ss_n) begin
                falls++;
                if (falls == 2) begin
                    f2 = c;
                    start_transfer = 1'b0;
                end
            end
            prev_ss = ss_n;
            if (transfer_done) begin
                n_done++;
                if (c1 < 0) c1 = c;
                else if (c2 < 0) c2 = c;
            end
            if (c2 >= 0 && c >= c2 + 3) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start_transfer = 1'b0;
        checks++; if (!fin) begin errors++; $display("FAIL held_timeout: got %0d done pulses want 2", n_done); end
        checks++; if (c1 != SS_LOW) begin errors++; $display("FAIL held_first_done: got cycle %0d want %0d", c1, SS_LOW); end
        checks++; if (f2 != c1 + 2) begin errors++; $display("FAIL held_restart: got cycle %0d want %0d", f2, c1 + 2); end
        checks++; if (n_done != 2) begin errors++; $display("FAIL held_done_cnt: got %0d want 2", n_done); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL held_rx: got %h want 96", rx_data); end
        checks++; if (slave_rx_data !== 8'h3C) begin errors++; $display("FAIL held_srx: got %h want 3c", slave_rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mo, mi;
        int rises, ssl, nd, nr, gap, stray;
        bit to;
        logic prev;
        idle(3);
        tx_data = 8'h77; slave_tx_data = 8'h33; start_transfer = 1'b1;
        @(posedge clk);
        #1;
        start_transfer = 1'b0;
        rises = 0; prev = 1'b0;
        for (int c = 0; c < MAX_CYC && rises < 4; c++) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises < 4) begin
                @(posedge clk);
                #1;
            end
        end
        idle(CLK_DIV + 1);
        checks++; if (rises != 4) begin errors++; $display("FAIL mid_reach4: got %0d rises want 4", rises); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL mid_ss_n: got %b want 1", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk: got %b want 0", sclk); end
        checks++; if ({mosi, miso} !== 2'b00) begin errors++; $display("FAIL mid_mosi_miso: got %b want 00", {mosi, miso}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rx: got %h want 00", rx_data); end
        checks++; if (slave_rx_data !== 8'h00) begin errors++; $display("FAIL mid_srx: got %h want 00", slave_rx_data); end
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            if (transfer_done || data_received || !ss_n) stray++;
            @(posedge clk);
            #1;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray: got %0d stray cycles want 0", stray); end
        xfer(8'h5A, 8'hAA, -1, 8'h00, mo, mi, rises, ssl, nd, nr, gap, to);
        checks++; if (rx_data !== 8'hAA) begin errors++; $display("FAIL mid_after_rx: got %h want aa", rx_data); end
        checks++; if (slave_rx_data !== 8'h5A) begin errors++; $display("FAIL mid_after_srx: got %h want 5a", slave_rx_data); end
    endtask

    task automatic test_slave_change();
        logic [7:0] mo, mi;
        int rises, ssl, nd, nr, gap;
        bit to;
        idle(2);
        xfer(8'hE7, 8'h18, 2 * CLK_DIV, 8'hFF, mo, mi, rises, ssl, nd, nr, gap, to);
        checks++; if (rx_data !== 8'h18) begin errors++; $display("FAIL chg_rx: got %h want 18", rx_data); end
        checks++; if (slave_rx_data !== 8'hE7) begin errors++; $display("FAIL chg_srx: got %h want e7", slave_rx_data); end
    endtask

    // Model: a lossless full-duplex byte swap, MSB first, fixed frame length.
    task automatic test_random();
        logic [7:0] tx, stx, exp_rx, exp_srx, mo, mi;
        int rises, ssl, nd, nr, gap;
        bit to;
        for (int i = 0; i < 12; i++) begin
            tx = 8'($urandom_range(0, 255));
            stx = 8'($urandom_range(0, 255));
            exp_rx = stx;
            exp_srx = tx;
            idle($urandom_range(0, 5));
            xfer(tx, stx, -1, 8'h00, mo, mi, rises, ssl, nd, nr, gap, to);
            checks++; if (to || nd != 1 || nr != 1) begin
                errors++; $display("FAIL rand_pulses[%0d]: got done=%0d drx=%0d want 1 1", i, nd, nr);
            end
            checks++; if (mo !== exp_srx || mi !== exp_rx) begin
                errors++; $display("FAIL rand_bus[%0d]: got mosi %h miso %h want %h %h", i, mo, mi, exp_srx, exp_rx);
            end
            checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL rand_rx[%0d]: got %h want %h", i, rx_data, exp_rx); end
            checks++; if (slave_rx_data !== exp_srx) begin
                errors++; $display("FAIL rand_srx[%0d]: got %h want %h", i, slave_rx_data, exp_srx);
            end
            checks++; if (ssl != SS_LOW) begin errors++; $display("FAIL rand_ss_low[%0d]: got %0d want %0d", i, ssl, SS_LOW); end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_second();
        test_zero_reply();
        test_held_start();
        test_reset_mid();
        test_slave_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
